// File: rtl/spi_frame_capture.sv
// spi_frame_capture
//   Receive-side deserializer placed after the bitshifter. It synchronizes
//   chip-select, serial clock and serial data into the system clock domain.
//   Inside each chip-select frame it assembles MSB-first words and queues
//   them in a small FIFO that the consumer drains with a valid/ready
//   handshake. It also reports per-frame word count, a short-frame error
//   and a sticky overflow flag.
//
// Ports
//   clk         system clock (50 MHz)
//   rst         synchronous, active-high reset
//   cs_in       frame select, active-high (asynchronous to clk)
//   sclk_in     serial clock; data is sampled on its rising edge
//   sdi_in      serial data, MSB first
//   word_data   head-of-FIFO word (0 while word_valid is low)
//   word_valid  FIFO not empty
//   word_ready  consumer pops the head when word_valid && word_ready
//   frame_done  one-cycle pulse at the end of a frame
//   frame_err   one-cycle pulse with frame_done when a partial word was dropped
//   frame_words complete words in the last frame, saturating at 255
//   overflow    sticky; set when a word is dropped on a full FIFO
//   clr_ovf     clears overflow (a simultaneous drop wins)
module spi_frame_capture #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   parameter int SYNC  = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cs_in,
   input  logic         sclk_in,
   input  logic         sdi_in,
   output logic [W-1:0] word_data,
   output logic         word_valid,
   input  logic         word_ready,
   output logic         frame_done,
   output logic         frame_err,
   output logic [7:0]   frame_words,
   output logic         overflow,
   input  logic         clr_ovf
);

   localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int BCW = $clog2(W);
   localparam int SCW = $clog2(SYNC + 1);

   localparam logic [BCW-1:0] BIT_LAST    = BCW'(W - 1);
   localparam logic [BCW-1:0] BIT_ONE     = BCW'(1);
   localparam logic [SCW-1:0] SETTLE_DONE = SCW'(SYNC);
   localparam logic [SCW-1:0] SETTLE_ONE  = SCW'(1);
   localparam logic [AW:0]    CNT_FULL    = (AW + 1)'(DEPTH);
   localparam logic [AW:0]    CNT_ONE     = (AW + 1)'(1);
   localparam logic [AW-1:0]  PTR_ONE     = AW'(1);

   typedef enum logic [1:0] {ARM, IDLE, ACTIVE} state_t;

   // ---- stage p0: input synchronizers and edge detection ----
   logic [SYNC-1:0] cs_sync, sclk_sync, sdi_sync;
   logic            cs_dly, sclk_dly;

   always_ff @(posedge clk) begin
      if (rst) begin
         cs_sync   <= '0;
         sclk_sync <= '0;
         sdi_sync  <= '0;
         cs_dly    <= 1'b0;
         sclk_dly  <= 1'b0;
      end else begin
         cs_sync   <= {cs_sync[SYNC-2:0], cs_in};
         sclk_sync <= {sclk_sync[SYNC-2:0], sclk_in};
         sdi_sync  <= {sdi_sync[SYNC-2:0], sdi_in};
         cs_dly    <= cs_sync[SYNC-1];
         sclk_dly  <= sclk_sync[SYNC-1];
      end
   end

   logic cs_s, sdi_s, cs_rise, cs_fall, sclk_rise;

   assign cs_s      = cs_sync[SYNC-1];
   assign sdi_s     = sdi_sync[SYNC-1];
   assign cs_rise   = cs_s & ~cs_dly;
   assign cs_fall   = ~cs_s & cs_dly;
   assign sclk_rise = sclk_sync[SYNC-1] & ~sclk_dly;

   // ---- stage p1: frame state machine and word assembly ----
   state_t         state, state_nxt;
   logic [SCW-1:0] settle;
   logic           start_frame, end_frame, take_bit;

   always_ff @(posedge clk) begin
      if (rst) state <= ARM;
      else     state <= state_nxt;
   end

   // The sync chains restart from 0 after reset, so their last stage reads 0
   // until SYNC cycles have passed. ARM waits for that before trusting a
   // low cs, otherwise a frame in progress at reset release would look like
   // a fresh cs rising edge.
   always_ff @(posedge clk) begin
      if (rst)                                     settle <= '0;
      else if (state == ARM && settle != SETTLE_DONE) settle <= settle + SETTLE_ONE;
   end

   always_comb begin
      state_nxt   = state;
      start_frame = 1'b0;
      end_frame   = 1'b0;
      take_bit    = 1'b0;
      case (state)
         ARM: begin
            if (settle == SETTLE_DONE && !cs_s) state_nxt = IDLE;
         end
         IDLE: begin
            if (cs_rise) begin
               state_nxt   = ACTIVE;
               start_frame = 1'b1;
            end
         end
         ACTIVE: begin
            // cs fall takes priority over a coincident sclk edge
            if (cs_fall) begin
               state_nxt = IDLE;
               end_frame = 1'b1;
            end else if (sclk_rise) begin
               take_bit = 1'b1;
            end
         end
         default: state_nxt = ARM;
      endcase
   end

   logic [BCW-1:0] bit_cnt;
   logic [W-2:0]   shreg;
   logic [W-1:0]   word_full;
   logic           word_done;

   assign word_full = {shreg, sdi_s};
   assign word_done = take_bit && (bit_cnt == BIT_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt     <= '0;
         shreg       <= '0;
         frame_words <= 8'd0;
         frame_done  <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         frame_done <= end_frame;
         frame_err  <= end_frame && (bit_cnt != '0);
         if (start_frame) begin
            bit_cnt     <= '0;
            frame_words <= 8'd0;
         end else if (take_bit) begin
            shreg <= word_full[W-2:0];
            if (word_done) begin
               bit_cnt <= '0;
               if (frame_words != 8'hFF) frame_words <= frame_words + 8'd1;
            end else begin
               bit_cnt <= bit_cnt + BIT_ONE;
            end
         end
      end
   end

   // ---- stage p2: output FIFO ----
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [AW:0]   cnt;
   logic          push, pop, full, wr_en, drop;

   assign push  = word_done;
   assign pop   = word_valid && word_ready;
   assign full  = (cnt == CNT_FULL);
   // When full, a same-cycle pop frees the slot the write lands in.
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= word_full;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
         case ({wr_en, pop})
            2'b10:   cnt <= cnt + CNT_ONE;
            2'b01:   cnt <= cnt - CNT_ONE;
            default: cnt <= cnt;
         endcase
         if (drop)         overflow <= 1'b1;
         else if (clr_ovf) overflow <= 1'b0;
      end
   end

   assign word_valid = (cnt != '0);
   assign word_data  = word_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_spi_frame_capture.sv
// Scoreboard bench for spi_frame_capture: stimulus pushes expected words and
// expected frame reports into queues; a monitor compares on each pop and on
// each frame_done pulse.
module tb_spi_frame_capture;
   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int SYNC  = 2;

   logic         clk = 1'b0;
   logic         rst, cs_in, sclk_in, sdi_in, word_ready, clr_ovf;
   logic [W-1:0] word_data;
   logic         word_valid, frame_done, frame_err, overflow;
   logic [7:0]   frame_words;

   always #10 clk = ~clk;

   spi_frame_capture #(.W(W), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
      .clk        (clk),
      .rst        (rst),
      .cs_in      (cs_in),
      .sclk_in    (sclk_in),
      .sdi_in     (sdi_in),
      .word_data  (word_data),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .frame_words(frame_words),
      .overflow   (overflow),
      .clr_ovf    (clr_ovf)
   );

   int           n_checks = 0;
   int           n_fail   = 0;
   int           pop_cnt  = 0;
   logic [W-1:0] exp_q [$];
   logic [8:0]   frm_q [$];   // {frame_err, frame_words}
   logic [8:0]   fe;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (word_valid && word_ready) begin
            pop_cnt++;
            chk("word_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) chk("word_data", 32'(word_data), 32'(exp_q.pop_front()));
         end
         if (frame_done) begin
            chk("frame_done_expected", 32'(frm_q.size() != 0), 32'(1));
            if (frm_q.size() != 0) begin
               fe = frm_q.pop_front();
               chk("frame_err", 32'(frame_err), 32'(fe[8]));
               chk("frame_words", 32'(frame_words), 32'(fe[7:0]));
            end
         end else if (frame_err) begin
            chk("frame_err_without_done", 32'(frame_err), 32'(0));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // mode 0: plain bit; 1: check word_valid latency; 2: pulse word_ready
   // so the pop lands on the same edge as this bit's push.
   task automatic send_bit(input logic b, input int mode);
      sdi_in = b;
      cyc(4);
      sclk_in = 1'b1;
      if (mode == 1) begin
         cyc(2);
         chk("latency_before", 32'(word_valid), 32'(0));
         cyc(1);
         chk("latency_after", 32'(word_valid), 32'(1));
         cyc(1);
      end else if (mode == 2) begin
         cyc(2);
         word_ready = 1'b1;
         cyc(1);
         word_ready = 1'b0;
         cyc(1);
      end else begin
         cyc(4);
      end
      sclk_in = 1'b0;
   endtask

   task automatic send_word(input logic [W-1:0] w, input int last_mode);
      for (int i = W - 1; i >= 0; i--) send_bit(w[i], (i == 0) ? last_mode : 0);
   endtask

   task automatic frame_begin();
      cs_in = 1'b1;
      cyc(4);
   endtask

   task automatic frame_end();
      cs_in = 1'b0;
      cyc(8);
   endtask

   task automatic drain();
      word_ready = 1'b1;
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) cyc(1);
      cyc(2);
      word_ready = 1'b0;
      chk("drain_queue_empty", 32'(exp_q.size()), 32'(0));
      chk("drain_valid_low", 32'(word_valid), 32'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      rst = 1'b1; cs_in = 1'b0; sclk_in = 1'b0; sdi_in = 1'b0;
      word_ready = 1'b0; clr_ovf = 1'b0;
      cyc(3);
      chk("reset_word_valid", 32'(word_valid), 32'(0));
      chk("reset_word_data", 32'(word_data), 32'(0));
      chk("reset_frame_done", 32'(frame_done), 32'(0));
      chk("reset_frame_err", 32'(frame_err), 32'(0));
      chk("reset_frame_words", 32'(frame_words), 32'(0));
      chk("reset_overflow", 32'(overflow), 32'(0));
      rst = 1'b0;
      cyc(6);

      // two-word frame
      frm_q.push_back({1'b0, 8'd2});
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'h3C);
      frame_begin();
      send_word(8'hA5, 1);
      send_word(8'h3C, 0);
      frame_end();
      chk("t1_frame_words_held", 32'(frame_words), 32'(2));
      drain();

      // 11-bit frame: one word plus a discarded partial word
      frm_q.push_back({1'b1, 8'd1});
      exp_q.push_back(8'h5A);
      frame_begin();
      send_word(8'h5A, 0);
      send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
      frame_end();
      chk("t2_frame_words_held", 32'(frame_words), 32'(1));
      drain();

      // overflow: six words into a four-deep FIFO with no pops
      frm_q.push_back({1'b0, 8'd6});
      exp_q.push_back(8'h11); exp_q.push_back(8'h22);
      exp_q.push_back(8'h33); exp_q.push_back(8'h44);
      frame_begin();
      send_word(8'h11, 0); send_word(8'h22, 0);
      send_word(8'h33, 0); send_word(8'h44, 0);
      chk("t3_no_overflow_at_4", 32'(overflow), 32'(0));
      send_word(8'h55, 0);
      chk("t3_overflow_after_5", 32'(overflow), 32'(1));
      send_word(8'h66, 0);
      chk("t3_overflow_sticky", 32'(overflow), 32'(1));
      clr_ovf = 1'b1;
      cyc(1);
      clr_ovf = 1'b0;
      chk("t3_overflow_cleared", 32'(overflow), 32'(0));
      frame_end();
      drain();

      // full FIFO with a pop on the same edge as the fifth push
      frm_q.push_back({1'b0, 8'd5});
      for (int i = 0; i < 5; i++) exp_q.push_back(8'(8'hB0 + i));
      frame_begin();
      for (int i = 0; i < 4; i++) send_word(8'(8'hB0 + i), 0);
      send_word(8'hB4, 2);
      chk("t4_no_overflow", 32'(overflow), 32'(0));
      frame_end();
      p0 = pop_cnt;
      drain();
      chk("t4_drain_count", 32'(pop_cnt - p0), 32'(4));

      // reset in the middle of a frame
      frame_begin();
      send_word(8'hE7, 0);
      send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      chk("t5_valid_after_rst", 32'(word_valid), 32'(0));
      chk("t5_words_after_rst", 32'(frame_words), 32'(0));
      for (int i = 0; i < 5; i++) send_bit(1'(i & 1), 0);
      frame_end();
      chk("t5_tail_ignored", 32'(word_valid), 32'(0));
      frm_q.push_back({1'b0, 8'd1});
      exp_q.push_back(8'h81);
      frame_begin();
      send_word(8'h81, 0);
      frame_end();
      drain();

      // sclk with cs low, then an sclk rise coincident with cs fall
      word_ready = 1'b1;
      send_word(8'hFF, 0);
      cyc(4);
      chk("t6_no_word_cs_low", 32'(word_valid), 32'(0));
      frm_q.push_back({1'b1, 8'd0});
      frame_begin();
      for (int i = 7; i >= 1; i--) send_bit(1'(i & 1), 0);
      sdi_in = 1'b0;
      cyc(4);
      cs_in   = 1'b0;
      sclk_in = 1'b1;
      cyc(4);
      sclk_in = 1'b0;
      cyc(6);
      chk("t6_coincident_no_word", 32'(frame_words), 32'(0));
      frm_q.push_back({1'b0, 8'd1});
      exp_q.push_back(8'hC3);
      frame_begin();
      send_word(8'hC3, 0);
      frame_end();
      drain();

      chk("final_word_queue", 32'(exp_q.size()), 32'(0));
      chk("final_frame_queue", 32'(frm_q.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/spi_frame_capture.md
# spi_frame_capture

Receive-side deserializer directly downstream of `bitshifter`. It samples the delayed chip-select (`o_cs`), serial clock (`o_clk`) and data (`miso`) on the 50 MHz system clock. It assembles MSB-first words inside each chip-select frame and hands them to the consumer through a small FIFO with a valid/ready handshake. It also reports per-frame status: word count, short-frame error and sticky overflow.

## Interface
Parameters:
- `W`, 8: word width in bits (2..16).
- `DEPTH`, 4: FIFO depth in words; power of two, 2..16.
- `SYNC`, 2: synchronizer stages applied identically to `cs_in`, `sclk_in` and `sdi_in` (≥2).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`, in, 1: system clock, 50 MHz.
- `rst`, in, 1: synchronous, active-high reset.
- `cs_in`, in, 1: frame select, active-high; driven from `bitshifter` `o_cs`.
- `sclk_in`, in, 1: serial clock; driven from `o_clk`. Data is sampled on its rising edge.
- `sdi_in`, in, 1: serial data; driven from `miso`.
- `word_data`, out, W: head-of-FIFO word.
- `word_valid`, out, 1: FIFO not empty.
- `word_ready`, in, 1: the consumer pops the head on a cycle where `word_valid && word_ready`.
- `frame_done`, out, 1: one-cycle pulse at end of frame.
- `frame_err`, out, 1: one-cycle pulse, coincident with `frame_done`, when the frame ended with a partial word.
- `frame_words`, out, 8: number of complete words in the last frame, saturating at 255. Held until the next frame starts.
- `overflow`, out, 1: sticky; set when a word is dropped because the FIFO is full.
- `clr_ovf`, in, 1: clears `overflow`. If a drop occurs in the same cycle, the set wins.

## Operation
- All three inputs pass through `SYNC`-stage flop chains. Edges are detected by comparing the last sync stage against one further registered copy.
- State machine states: `ARM`, `IDLE`, `ACTIVE`.
  - `ARM` is the reset state. It moves to `IDLE` when synced cs = 0. This guarantees that a frame already in progress at reset release is never captured.
  - `IDLE` moves to `ACTIVE` on a synced cs rising edge. On that transition the bit counter and `frame_words` are cleared.
  - `ACTIVE` moves to `IDLE` on a synced cs falling edge. On that transition `frame_done` pulses. `frame_err` also pulses if the bit counter is nonzero, and the partial word is discarded.
- In `ACTIVE`, each synced sclk rising edge does two things:
  - shifts the synced sdi into the LSB of the shift register (MSB-first order);
  - increments the bit counter.
- When the W-th bit arrives:
  - the full word, including that bit, is pushed to the FIFO that same cycle;
  - the bit counter returns to 0;
  - `frame_words` increments, saturating at 255.
- Sclk edges in `ARM` or `IDLE` are ignored.
- If cs falling and sclk rising are detected in the same cycle, cs falling has priority and the sclk edge is ignored.
- FIFO rules:
  - Pointers wrap modulo `DEPTH`. An occupancy counter of width log2(DEPTH)+1 decides full and empty.
  - Push when full with no pop in the same cycle: the word is dropped, `overflow` is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle when full: both succeed and occupancy is unchanged.
  - Push and pop in the same cycle when empty: only the push happens.
- `word_data` is undefined when `word_valid` = 0. It must stay stable while `word_valid && !word_ready`.
- Reset in the middle of a frame:
  - the FIFO is emptied and the shift register and counters are cleared;
  - no `frame_done` or `frame_err` pulse is emitted;
  - the FSM returns to `ARM`.

## Timing
- Reset values:
  - `word_valid` = 0, `word_data` = 0;
  - `frame_done` = 0, `frame_err` = 0;
  - `frame_words` = 0, `overflow` = 0;
  - sync chains all 0, state `ARM`.
- Word latency: when the final sclk high of a word is first sampled at clk edge k into an empty FIFO, `word_valid` is 1 after edge k+SYNC.
- Frame-end latency: when cs low is first sampled at edge k, `frame_done` is high for the single cycle following edge k+SYNC.
- Pop: after an accepted handshake at edge p, the next word (or `word_valid` = 0) is visible after edge p. There is no bubble, so one word per cycle is sustainable.
- Input requirements:
  - sclk high and low phases each ≥ SYNC+1 clk cycles;
  - sdi stable ≥ 1 clk before and ≥ 1 clk after each sclk rising edge;
  - cs high ≥ SYNC+1 cycles before the first sclk rising edge.

## Test plan
- Reset, then a frame with `cs_in` = 1 and 16 sclk pulses carrying 0xA5, 0x3C (each phase 4 clk), then cs low → two words, 0xA5 then 0x3C. `word_valid` rises SYNC cycles after the final bit's sclk rise; `frame_done` pulses once; `frame_words` = 2; `frame_err` = 0.
- Frame with 11 bits → one word pushed; `frame_err` and `frame_done` pulse together; `frame_words` = 1; the 3 leftover bits never appear in the FIFO.
- `word_ready` held 0 while 6 words are sent with DEPTH = 4 → 4 words retained in order; `overflow` = 1 after the 5th word. Pulsing `clr_ovf` clears it. Draining then returns the first 4 words.
- FIFO full, with `word_ready` = 1 in the same cycle as a push → no overflow; occupancy stays 4; output order is preserved.
- `rst` pulsed mid-word while cs is high → `word_valid` = 0 and no `frame_done`. Bits from the rest of that frame are ignored. The next full cs frame carrying 0x81 yields exactly 0x81.
- Sclk pulses with cs low, and an sclk rise detected in the same cycle as the cs fall → no word pushed, and the bit counter is unaffected.
